// File: rtl/axi_lite_master_cmd_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_master_cmd_if                                                   |
// | Command/response port plus AXI4-Lite master bus for axi_lite_master_cmd. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface axi_lite_master_cmd_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 32
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;
  logic                    rsp_timeout;

  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [2:0]              m_axi_awprot;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [2:0]              m_axi_arprot;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
    output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout,
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid, m_axi_rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_master_cmd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_master_cmd                                                      |
// | Single-outstanding AXI4-Lite master: one command in, one response out.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module axi_lite_master_cmd #(
  parameter int C_M_AXI_ADDR_WIDTH = 40,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                 axi_aclk,
  input  logic                 axi_areset,
  axi_lite_master_cmd_if.master bus
);
  localparam int STRB_WIDTH = C_M_AXI_DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT =
    (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_RESP = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_RESP = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  logic [2:0]                    state;
  logic [2:0]                    state_nxt;

  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0]         wstrb_q;
  logic                          aw_done;
  logic                          w_done;
  logic [CNT_WIDTH-1:0]          tmo_cnt;
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    resp_q;
  logic                          timeout_q;

  logic cmd_ready;
  logic rsp_valid;
  logic awvalid;
  logic wvalid;
  logic arvalid;
  logic bready;
  logic rready;

  logic cmd_fire;
  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic b_hs;
  logic r_hs;
  logic busy;
  logic timeout_hit;

  assign cmd_fire = (state == S_IDLE) && bus.cmd_valid;
  assign aw_hs    = awvalid && bus.m_axi_awready;
  assign w_hs     = wvalid  && bus.m_axi_wready;
  assign ar_hs    = arvalid && bus.m_axi_arready;
  assign b_hs     = bready  && bus.m_axi_bvalid;
  assign r_hs     = rready  && bus.m_axi_rvalid;
  assign busy     = (state == S_WR_REQ) || (state == S_WR_RESP) ||
                    (state == S_RD_REQ) || (state == S_RD_RESP);
  // Fires on the TIMEOUT_CYCLES-th busy cycle after the command was accepted
  assign timeout_hit = TIMEOUT_EN && busy && (tmo_cnt == CNT_LIMIT);

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_fire) begin
          state_nxt = bus.cmd_write ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (timeout_hit) begin
          state_nxt = S_RSP;
        end else if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_nxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (b_hs || timeout_hit) begin
          state_nxt = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (timeout_hit) begin
          state_nxt = S_RSP;
        end else if (ar_hs) begin
          state_nxt = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (r_hs || timeout_hit) begin
          state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are decoded from registered state only, so a timeout
  // or reset removes them on the very next cycle.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    arvalid   = 1'b0;
    bready    = 1'b0;
    rready    = 1'b0;
    case (state)
      S_IDLE:    cmd_ready = 1'b1;
      S_WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
      end
      S_WR_RESP: bready    = 1'b1;
      S_RD_REQ:  arvalid   = 1'b1;
      S_RD_RESP: rready    = 1'b1;
      S_RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_q  <= bus.cmd_addr;
        wdata_q <= bus.cmd_wdata;
        wstrb_q <= bus.cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        tmo_cnt <= '0;
      end else begin
        if (aw_hs) begin
          aw_done <= 1'b1;
        end
        if (w_hs) begin
          w_done <= 1'b1;
        end
        if (busy && TIMEOUT_EN) begin
          tmo_cnt <= tmo_cnt + CNT_WIDTH'(1);
        end
      end

      // A real response arriving on the limit cycle takes priority
      if (b_hs) begin
        rdata_q   <= '0;
        resp_q    <= bus.m_axi_bresp;
        timeout_q <= 1'b0;
      end else if (r_hs) begin
        rdata_q   <= bus.m_axi_rdata;
        resp_q    <= bus.m_axi_rresp;
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q   <= '0;
        resp_q    <= 2'b11;
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready     = cmd_ready;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_rdata     = rdata_q;
  assign bus.rsp_resp      = resp_q;
  assign bus.rsp_timeout   = timeout_q;

  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = awvalid;
  assign bus.m_axi_wdata   = wdata_q;
  assign bus.m_axi_wstrb   = wstrb_q;
  assign bus.m_axi_wvalid  = wvalid;
  assign bus.m_axi_bready  = bready;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = arvalid;
  assign bus.m_axi_rready  = rready;
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_master_cmd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_axi_lite_master_cmd                                                   |
// | Directed bench with a 16-register AXI4-Lite slave model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_axi_lite_master_cmd;
  localparam int AW  = 40;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_lite_master_cmd_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  axi_lite_master_cmd #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .axi_aclk  (clk),
    .axi_areset(rst),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;

  // Slave behaviour knobs
  logic aw_block = 1'b0;
  logic b_hang   = 1'b0;
  logic r_hang   = 1'b0;
  int   w_delay  = 0;

  logic [31:0]   regs [16];
  logic          aw_got, w_got;
  logic [AW-1:0] aw_addr_q;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  int            w_wait;

  logic          s_aw, s_w, s_ok, ar_ok;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_data;
  logic [3:0]    s_strb;

  assign bus.m_axi_awready = !aw_block;
  assign bus.m_axi_wready  = (w_wait >= w_delay);
  assign bus.m_axi_arready = 1'b1;

  assign s_aw   = aw_got || (bus.m_axi_awvalid && bus.m_axi_awready);
  assign s_w    = w_got  || (bus.m_axi_wvalid  && bus.m_axi_wready);
  assign s_addr = aw_got ? aw_addr_q : bus.m_axi_awaddr;
  assign s_data = w_got  ? w_data_q  : bus.m_axi_wdata;
  assign s_strb = w_got  ? w_strb_q  : bus.m_axi_wstrb;
  assign s_ok   = (s_addr[AW-1:6] == '0);
  assign ar_ok  = (bus.m_axi_araddr[AW-1:6] == '0);

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      aw_got           <= 1'b0;
      w_got            <= 1'b0;
      w_wait           <= 0;
      bus.m_axi_bvalid <= 1'b0;
      bus.m_axi_bresp  <= 2'b00;
      bus.m_axi_rvalid <= 1'b0;
      bus.m_axi_rdata  <= 32'h0;
      bus.m_axi_rresp  <= 2'b00;
      for (int i = 0; i < 16; i++) regs[i] <= 32'h0;
      regs[0] <= 32'hDEADBEEF;
      regs[1] <= 32'h76543210;
    end else begin
      if (bus.m_axi_awvalid && bus.m_axi_awready) begin
        aw_got    <= 1'b1;
        aw_addr_q <= bus.m_axi_awaddr;
      end
      if (bus.m_axi_wvalid && bus.m_axi_wready) begin
        w_got    <= 1'b1;
        w_data_q <= bus.m_axi_wdata;
        w_strb_q <= bus.m_axi_wstrb;
        w_wait   <= 0;
      end else if (bus.m_axi_wvalid) begin
        w_wait <= w_wait + 1;
      end
      if (bus.m_axi_bvalid && bus.m_axi_bready) bus.m_axi_bvalid <= 1'b0;
      if (s_aw && s_w) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (s_ok) regs[s_addr[5:2]] <= merge(regs[s_addr[5:2]], s_data, s_strb);
        bus.m_axi_bresp <= s_ok ? 2'b00 : 2'b10;
        if (!b_hang) bus.m_axi_bvalid <= 1'b1;
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) bus.m_axi_rvalid <= 1'b0;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        bus.m_axi_rdata <= ar_ok ? regs[bus.m_axi_araddr[5:2]] : 32'hBAD0BAD0;
        bus.m_axi_rresp <= ar_ok ? 2'b00 : 2'b10;
        if (!r_hang) bus.m_axi_rvalid <= 1'b1;
      end
    end
  end

  // Bus activity counters sampled mid-cycle
  int          w_stall_cnt = 0, b_hs_cnt = 0, aw_hs_cnt = 0, ar_hs_cnt = 0, hold_viol = 0;
  logic        prev_wv = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_wd = 32'h0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_axi_wvalid && !bus.m_axi_wready)   w_stall_cnt <= w_stall_cnt + 1;
      if (bus.m_axi_bvalid && bus.m_axi_bready)    b_hs_cnt    <= b_hs_cnt + 1;
      if (bus.m_axi_awvalid && bus.m_axi_awready)  aw_hs_cnt   <= aw_hs_cnt + 1;
      if (bus.m_axi_arvalid && bus.m_axi_arready)  ar_hs_cnt   <= ar_hs_cnt + 1;
      if (prev_wv && !prev_wr && (!bus.m_axi_wvalid || bus.m_axi_wdata != prev_wd))
        hold_viol <= hold_viol + 1;
    end
    prev_wv <= bus.m_axi_wvalid;
    prev_wr <= bus.m_axi_wready;
    prev_wd <= bus.m_axi_wdata;
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_wstrb = s;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Latency counted from the first cycle after command acceptance (that cycle = 1)
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    if (bus.rsp_valid !== 1'b1) lat = -1;
  endtask

  task automatic ack_rsp();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
         bus.m_axi_rready, bus.rsp_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_valids: got aw%b w%b ar%b b%b r%b rsp%b want all 0",
        bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
        bus.m_axi_rready, bus.rsp_valid);
    end
    checks++;
    if ({bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata} !== 35'h0) begin
      errors++; $display("FAIL reset_rsp: got resp=%b tmo=%b rdata=%h want 0",
        bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.m_axi_awvalid !== 1'b0 || bus.m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle: got cmd_ready=%b awv=%b arv=%b want 1 0 0",
        bus.cmd_ready, bus.m_axi_awvalid, bus.m_axi_arvalid);
    end
  endtask

  task automatic test_write_read();
    int lat;
    issue(1'b1, 40'h8, 32'hA5A5A5A5, 4'hF);
    checks++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.cmd_ready} !== 4'b1100) begin
      errors++; $display("FAIL wr_req_valids: got aw%b w%b ar%b cr%b want 1 1 0 0",
        bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.cmd_ready);
    end
    checks++;
    if (bus.m_axi_awaddr !== 40'h8 || bus.m_axi_wdata !== 32'hA5A5A5A5 ||
        bus.m_axi_wstrb !== 4'hF || bus.m_axi_awprot !== 3'b000) begin
      errors++; $display("FAIL wr_req_payload: got addr=%h data=%h strb=%h prot=%b want 8 a5a5a5a5 f 0",
        bus.m_axi_awaddr, bus.m_axi_wdata, bus.m_axi_wstrb, bus.m_axi_awprot);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL wr_latency: got %0d want 3", lat); end
    checks++;
    if ({bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata} !== {2'b00, 1'b0, 32'h0}) begin
      errors++; $display("FAIL wr_rsp: got resp=%b tmo=%b rdata=%h want 00 0 0",
        bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata);
    end
    ack_rsp();
    issue(1'b0, 40'h8, 32'h0, 4'h0);
    checks++;
    if ({bus.m_axi_awvalid, bus.m_axi_arvalid} !== 2'b01 || bus.m_axi_araddr !== 40'h8 ||
        bus.m_axi_arprot !== 3'b000) begin
      errors++; $display("FAIL rd_req: got awv=%b arv=%b addr=%h prot=%b want 0 1 8 0",
        bus.m_axi_awvalid, bus.m_axi_arvalid, bus.m_axi_araddr, bus.m_axi_arprot);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3 || bus.rsp_rdata !== 32'hA5A5A5A5 || bus.rsp_resp !== 2'b00 ||
        bus.rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL rd_back_0x8: got lat=%0d rdata=%h resp=%b tmo=%b want 3 a5a5a5a5 00 0",
        lat, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout);
    end
    ack_rsp();
  endtask

  task automatic test_read_regs();
    int lat;
    logic [AW-1:0] addrs [3];
    logic [31:0]   exp_d [3];
    logic [1:0]    exp_r [3];
    addrs[0] = 40'h0;   exp_d[0] = 32'hDEADBEEF; exp_r[0] = 2'b00;
    addrs[1] = 40'h4;   exp_d[1] = 32'h76543210; exp_r[1] = 2'b00;
    addrs[2] = 40'h100; exp_d[2] = 32'hBAD0BAD0; exp_r[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, addrs[i], 32'h0, 4'h0);
      wait_rsp(lat);
      checks++;
      if (lat != 3 || bus.rsp_rdata !== exp_d[i] || bus.rsp_resp !== exp_r[i] ||
          bus.rsp_timeout !== 1'b0) begin
        errors++; $display("FAIL read_%h: got lat=%0d rdata=%h resp=%b tmo=%b want 3 %h %b 0",
          addrs[i], lat, bus.rsp_rdata, bus.rsp_resp, bus.rsp_timeout, exp_d[i], exp_r[i]);
      end
      ack_rsp();
    end
  endtask

  task automatic test_w_delay();
    int lat, st0, b0, aw0, hv0;
    st0 = w_stall_cnt; b0 = b_hs_cnt; aw0 = aw_hs_cnt; hv0 = hold_viol;
    w_delay = 5;
    issue(1'b1, 40'hC, 32'h12345678, 4'b0011);
    wait_rsp(lat);
    checks++;
    if (lat != 8 || bus.rsp_resp !== 2'b00 || bus.rsp_timeout !== 1'b0) begin
      errors++; $display("FAIL wdelay_rsp: got lat=%0d resp=%b tmo=%b want 8 00 0",
        lat, bus.rsp_resp, bus.rsp_timeout);
    end
    ack_rsp();
    w_delay = 0;
    checks++;
    if (w_stall_cnt - st0 != 5 || hold_viol - hv0 != 0) begin
      errors++; $display("FAIL wdelay_hold: got stalls=%0d drops=%0d want 5 0",
        w_stall_cnt - st0, hold_viol - hv0);
    end
    checks++;
    if (b_hs_cnt - b0 != 1 || aw_hs_cnt - aw0 != 1) begin
      errors++; $display("FAIL wdelay_hs_count: got b=%0d aw=%0d want 1 1",
        b_hs_cnt - b0, aw_hs_cnt - aw0);
    end
    issue(1'b0, 40'hC, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (bus.rsp_rdata !== 32'h00005678) begin
      errors++; $display("FAIL wstrb_merge: got %h want 00005678", bus.rsp_rdata);
    end
    ack_rsp();
  endtask

  task automatic test_timeout();
    int lat;
    r_hang = 1'b1;
    issue(1'b0, 40'h4, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (lat != TMO + 1) begin
      errors++; $display("FAIL rd_timeout_latency: got %0d want %0d", lat, TMO + 1);
    end
    checks++;
    if ({bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata} !== {2'b11, 1'b1, 32'h0} ||
        bus.m_axi_rready !== 1'b0 || bus.m_axi_arvalid !== 1'b0) begin
      errors++; $display("FAIL rd_timeout_rsp: got resp=%b tmo=%b rdata=%h rready=%b want 11 1 0 0",
        bus.rsp_resp, bus.rsp_timeout, bus.rsp_rdata, bus.m_axi_rready);
    end
    ack_rsp();
    r_hang = 1'b0;
    b_hang = 1'b1;
    issue(1'b1, 40'h10, 32'h1, 4'hF);
    wait_rsp(lat);
    checks++;
    if (lat != TMO + 1 || bus.rsp_resp !== 2'b11 || bus.rsp_timeout !== 1'b1 ||
        bus.m_axi_bready !== 1'b0) begin
      errors++; $display("FAIL wr_timeout: got lat=%0d resp=%b tmo=%b bready=%b want %0d 11 1 0",
        lat, bus.rsp_resp, bus.rsp_timeout, bus.m_axi_bready, TMO + 1);
    end
    ack_rsp();
    b_hang = 1'b0;
    issue(1'b0, 40'h0, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_timeout !== 1'b0 ||
        bus.rsp_resp !== 2'b00) begin
      errors++; $display("FAIL after_timeout_read: got lat=%0d rdata=%h tmo=%b resp=%b want 3 deadbeef 0 00",
        lat, bus.rsp_rdata, bus.rsp_timeout, bus.rsp_resp);
    end
    ack_rsp();
  endtask

  task automatic test_rsp_backpressure();
    int lat, ar0, aw0;
    issue(1'b0, 40'h4, 32'h0, 4'h0);
    wait_rsp(lat);
    ar0 = ar_hs_cnt; aw0 = aw_hs_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 40'h14;
    bus.cmd_wdata = 32'hCAFEF00D;
    bus.cmd_wstrb = 4'hF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h76543210 || bus.rsp_resp !== 2'b00 ||
          bus.cmd_ready !== 1'b0 || bus.m_axi_awvalid !== 1'b0 || bus.m_axi_arvalid !== 1'b0) begin
        errors++; $display("FAIL rsp_hold_c%0d: got v=%b rdata=%h resp=%b cr=%b awv=%b arv=%b want 1 76543210 00 0 0 0",
          c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_resp, bus.cmd_ready,
          bus.m_axi_awvalid, bus.m_axi_arvalid);
      end
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (ar_hs_cnt != ar0 || aw_hs_cnt != aw0) begin
      errors++; $display("FAIL rsp_hold_bus_quiet: got ar=%0d aw=%0d new handshakes want 0 0",
        ar_hs_cnt - ar0, aw_hs_cnt - aw0);
    end
    ack_rsp();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rsp_release: got rsp_valid=%b cmd_ready=%b want 0 1",
        bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    aw_block = 1'b1;
    issue(1'b1, 40'h8, 32'h11111111, 4'hF);
    @(posedge clk); #1;
    checks++;
    if (bus.m_axi_awvalid !== 1'b1 || bus.m_axi_wvalid !== 1'b0 || bus.m_axi_awaddr !== 40'h8) begin
      errors++; $display("FAIL aw_held_w_done: got awv=%b wv=%b addr=%h want 1 0 8",
        bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_awaddr);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
         bus.m_axi_rready, bus.rsp_valid, bus.cmd_ready} !== 7'b0000001) begin
      errors++; $display("FAIL mid_reset: got aw%b w%b ar%b b%b r%b rsp%b cr%b want 0 0 0 0 0 0 1",
        bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_arvalid, bus.m_axi_bready,
        bus.m_axi_rready, bus.rsp_valid, bus.cmd_ready);
    end
    rst = 1'b0;
    aw_block = 1'b0;
    @(posedge clk); #1;
    issue(1'b0, 40'h0, 32'h0, 4'h0);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_resp !== 2'b00) begin
      errors++; $display("FAIL after_reset_read: got lat=%0d rdata=%h resp=%b want 3 deadbeef 00",
        lat, bus.rsp_rdata, bus.rsp_resp);
    end
    ack_rsp();
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_wstrb = 4'h0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_read_regs();
    test_w_delay();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
`default_nettype wire
